// File: rtl/seq1011_stream_ctrl_if.sv
// Word handshake and detector status bundle for seq1011_stream_ctrl.
// master: word producer / monitor side; slave: the controller.
interface seq1011_stream_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             x;
  logic             detect;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in_data,
    input  in_ready, x, detect, busy, done, match_count
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, x, detect, busy, done, match_count
  );
endinterface

// File: rtl/seq1011_stream_ctrl.sv
// Word-level front end for a Mealy "1011" detector: accepts a word on a
// valid/ready handshake, shifts it MSB-first through the detector one bit per
// clock, counts matches per word and pulses done when the count is final.
// Optional feature macro: SEQ1011_OVERLAP_EN (overlapping detection).
module seq1011_stream_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  seq1011_stream_ctrl_if.slave bus
);

  localparam int unsigned BitCntW = $clog2(WIDTH);
  localparam logic [BitCntW-1:0] BitCntLoad = BitCntW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {DetS0, DetS1, DetS2, DetS3} det_e;

  state_e             state_q, state_d;
  det_e               det_q, det_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               detect_q, detect_d;
  logic               shift_en;
  logic               x_bit;
  logic               match;

  assign shift_en = (state_q == StShift);
  assign x_bit    = shift_en & shreg_q[WIDTH-1];

  // State register: FSM, detector and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      det_q     <= DetS0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      detect_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      detect_q  <= detect_d;
    end
  end

  // Controller next state: accept in IDLE, leave SHIFT after bit 0 is consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StShift;
      StShift: if (bit_cnt_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Detector next state; it only advances while a bit is being shifted out.
  always_comb begin
    det_d = det_q;
    match = 1'b0;
    if (shift_en) begin
      unique case (det_q)
        DetS0: det_d = x_bit ? DetS1 : DetS0;
        DetS1: det_d = x_bit ? DetS1 : DetS2;
        DetS2: det_d = x_bit ? DetS3 : DetS0;
        DetS3: begin
          if (x_bit) begin
            match = 1'b1;
`ifdef SEQ1011_OVERLAP_EN
            det_d = DetS1;
`else
            det_d = DetS0;
`endif
          end else begin
            det_d = DetS2;
          end
        end
        default: det_d = DetS0;
      endcase
    end
  end

  // Datapath next state: load on accept, shift/decrement/count during SHIFT.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    detect_d  = match;
    if (state_q == StIdle && bus.in_valid) begin
      shreg_d   = bus.in_data;
      bit_cnt_d = BitCntLoad;
      cnt_d     = '0;
    end else if (shift_en) begin
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 1'b1;
      // Saturate rather than wrap so an overflowing word still reads as "many".
      if (match && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.in_ready    = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
    bus.x           = x_bit;
    bus.detect      = detect_q;
    bus.match_count = cnt_q;
  end

endmodule

// File: tb/tb_seq1011_stream_ctrl.sv
// Directed bench for seq1011_stream_ctrl: a CNT_W=4 instance for the main
// tests and a CNT_W=1 instance for counter saturation.
module tb_seq1011_stream_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq1011_stream_ctrl_if #(.WIDTH(WIDTH), .CNT_W(4)) bus ();
  seq1011_stream_ctrl_if #(.WIDTH(WIDTH), .CNT_W(1)) sbus ();

  seq1011_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq1011_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Observation mux so one send task serves both instances.
  bit         use_sat = 1'b0;
  logic       det_s, done_s, rdy_s, busy_s, x_s;
  logic [3:0] cnt_s;
  assign det_s  = use_sat ? sbus.detect   : bus.detect;
  assign done_s = use_sat ? sbus.done     : bus.done;
  assign rdy_s  = use_sat ? sbus.in_ready : bus.in_ready;
  assign busy_s = use_sat ? sbus.busy     : bus.busy;
  assign x_s    = use_sat ? sbus.x        : bus.x;
  assign cnt_s  = use_sat ? {3'b000, sbus.match_count} : bus.match_count;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Send one word from IDLE and watch the WIDTH+2 cycles after the accept edge.
  // det_mask bit k is set if detect was high in the cycle after edge Ek.
  task automatic send_word(input bit sel, input logic [7:0] w, output int det_mask,
                           output int done_at, output int cnt_done, output int ready_at);
    det_mask = 0;
    done_at  = -1;
    cnt_done = -1;
    ready_at = -1;
    use_sat  = sel;
    @(negedge clk);
    if (sel) begin
      sbus.in_valid = 1'b1;
      sbus.in_data  = w;
    end else begin
      bus.in_valid = 1'b1;
      bus.in_data  = w;
    end
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    bus.in_valid  = 1'b0;
    for (int k = 1; k <= WIDTH + 2; k++) begin
      @(posedge clk);
      #1;
      if (det_s) det_mask |= (1 << k);
      if (done_s && done_at < 0) begin
        done_at  = k;
        cnt_done = int'(cnt_s);
      end
      if (rdy_s && ready_at < 0) ready_at = k;
    end
  endtask

  int m, d, c, r;
  int acc[$];
  bit took;
  bit done_seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    sbus.in_valid = 1'b0;
    sbus.in_data  = '0;

    // Reset: in_valid must be ignored while rst is high.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_x", bus.x, 0);
    check("rst_done", bus.done, 0);
    check("rst_detect", bus.detect, 0);
    check("rst_count", bus.match_count, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 10110000: single match at E4, done after E8, ready again after E9.
    send_word(1'b0, 8'hB0, m, d, c, r);
    check("b0_detect_mask", m, 32'h10);
    check("b0_done_at", d, WIDTH);
    check("b0_count", c, 1);
    check("b0_ready_at", r, WIDTH + 1);

    // 10110110: overlap gives a second match at E7.
    send_word(1'b0, 8'b10110110, m, d, c, r);
`ifdef SEQ1011_OVERLAP_EN
    check("ovl_detect_mask", m, (1 << 4) | (1 << 7));
    check("ovl_count", c, 2);
`else
    check("novl_detect_mask", m, 1 << 4);
    check("novl_count", c, 1);
`endif
    check("ovl_done_at", d, WIDTH);

    // Detector was left in S2; a zero word returns it to S0.
    send_word(1'b0, 8'h00, m, d, c, r);
    check("flush_count", c, 0);

    // Match spanning a word boundary.
    send_word(1'b0, 8'b00000101, m, d, c, r);
    check("span1_count", c, 0);
    check("span1_detect_mask", m, 0);
    send_word(1'b0, 8'b10000000, m, d, c, r);
    check("span2_detect_mask", m, 1 << 1);
    check("span2_count", c, 1);

    // Backpressure: in_valid held high, words alternate 00/FF.
    use_sat = 1'b0;
    acc.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int cyc = 0; cyc < 34; cyc++) begin
      if (cyc != 0) @(negedge clk);
      took = bus.in_ready;
      if (took) acc.push_back(cyc);
      @(posedge clk);
      #1;
      if (took) begin
        check("bp_ready_drops", bus.in_ready, 0);
        bus.in_data = ~bus.in_data;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepts", acc.size(), 4);
    if (acc.size() == 4) begin
      check("bp_gap1", acc[1] - acc[0], WIDTH + 2);
      check("bp_gap2", acc[2] - acc[1], WIDTH + 2);
      check("bp_gap3", acc[3] - acc[2], WIDTH + 2);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) break;
      @(posedge clk);
      #1;
    end
    check("bp_idle", bus.in_ready, 1);
    // Last word was FF (detector in S1); clear it.
    send_word(1'b0, 8'h00, m, d, c, r);
    check("bp_flush_count", c, 0);

    // Asynchronous reset in the middle of SHIFT, just after E3 of 10110000.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy_before", bus.busy, 1);
    check("mid_x_before", bus.x, 1);
    rst = 1'b1;
    #1;
    check("mid_busy", bus.busy, 0);
    check("mid_x", bus.x, 0);
    check("mid_in_ready", bus.in_ready, 1);
    check("mid_done", bus.done, 0);
    check("mid_detect", bus.detect, 0);
    check("mid_count", bus.match_count, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    check("mid_no_done", done_seen, 0);
    send_word(1'b0, 8'hB0, m, d, c, r);
    check("post_rst_count", c, 1);
    check("post_rst_detect_mask", m, 1 << 4);

    // Saturation on the CNT_W=1 instance: 10111011 has two matches either way.
    send_word(1'b1, 8'b10111011, m, d, c, r);
    check("sat_detect_mask", m, (1 << 4) | (1 << 8));
    check("sat_count", c, 1);
    check("sat_done_at", d, WIDTH);
    check("sat_idle_busy", busy_s, 0);
    check("sat_idle_x", x_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq1011_stream_ctrl.md
# seq1011_stream_ctrl

Word-level controller for the bit-serial "1011" sequence detector. It accepts parallel words over a valid/ready handshake and shifts them MSB-first into an embedded Mealy 1011 detector, one bit per clock. It counts matches per word and reports the count with a one-cycle done pulse. It sits between a word-oriented producer (bus or FIFO) and the serial detection datapath, so upstream logic never drives the serial `x` input bit by bit.

## Interface
- `WIDTH`, default 8: bits per input word; must be ≥ 4.
- `CNT_W`, default 4: width of the per-word match counter.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_data`  input  WIDTH  word to scan; the MSB is shifted first.
- `in_ready`  output  1  controller can accept a word; high only in IDLE.
- `x`  output  1  serial bit currently presented to the detector; 0 outside SHIFT.
- `detect`  output  1  registered pulse, high for one cycle after the edge that consumed the final 1 of a 1011 match.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse; `match_count` is final while it is high.
- `match_count`  output  CNT_W  matches found in the current or most recent word.

## Operation
- Controller FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On an edge with `in_valid` = 1: latch `in_data` into the shift register, clear `match_count` to 0, load bit counter with WIDTH−1, go to SHIFT.
- **SHIFT**
  - `x` = shift register MSB.
  - Each edge: the detector consumes `x`, the shift register shifts left, and the bit counter decrements.
  - On the edge that consumes bit 0, go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle, then go to IDLE.
- Detector states: S0 (nothing), S1 (seen "1"), S2 (seen "10"), S3 (seen "101").
  - S0: x=1 → S1; x=0 → S0.
  - S1: x=0 → S2; x=1 → S1.
  - S2: x=1 → S3; x=0 → S0.
  - S3: x=0 → S2; x=1 → match (see Configuration for the next state).
- Detector state advances only on SHIFT edges. It persists across words, so a match may span a word boundary. It is cleared only by `rst`.
- On a match edge: `detect` goes to 1 for the next cycle, and `match_count` increments, saturating at 2^CNT_W−1.
- `in_valid` outside IDLE is ignored; no data is lost because `in_ready` = 0 there.

## Timing
- Reset values:
  - FSM = IDLE; detector = S0; shift register = 0; `match_count` = 0.
  - `detect` = 0, `done` = 0, `busy` = 0, `x` = 0.
  - `in_ready` = 1, but `in_valid` is ignored while `rst` is high.
- Let edge E0 be the accepting handshake edge. Then:
  - SHIFT spans the cycles after E0 through edge E(WIDTH).
  - `done` is high in the cycle after E(WIDTH).
  - `in_ready` is high again the cycle after that.
  - Throughput is one word per WIDTH+2 cycles.
- Match latency: a match completed by the bit consumed at edge Ek gives `detect` = 1 and the incremented `match_count` during the cycle after Ek.
- `match_count` holds its value through DONE and IDLE until the next accept.
- Reset mid-SHIFT: all state returns to reset values immediately (asynchronously); the partial word is discarded and no `done` pulse is generated.

## Configuration
- `SEQ1011_OVERLAP_EN`
  - Defined: overlapping detection. After a match, S3 with x=1 → S1, so "1011011" yields 2 matches.
  - Undefined: non-overlapping detection. After a match, S3 with x=1 → S0, so "1011011" yields 1 match.

## Test plan
- Reset, then send `in_data` = 8'hB0 (10110000) → one `detect` pulse, in the cycle after E4; `done` in the cycle after E8 with `match_count` = 1; `in_ready` = 1 at E10.
- Send 8'b10110110:
  - With `SEQ1011_OVERLAP_EN`: `detect` after E4 and after E7; `match_count` = 2.
  - Without it: `detect` after E4 only; `match_count` = 1.
- Boundary-spanning match: send 8'b00000101 → `match_count` = 0 (detector left in S3). Then send 8'b10000000 → `detect` after E1 of the second word; `match_count` = 1.
- Saturation with CNT_W = 1 and overlap enabled: send 8'b10110110 → `match_count` = 1 (saturated); two `detect` pulses are still seen.
- Backpressure: hold `in_valid` high with alternating words → each word accepted only when `in_ready` = 1, with exactly WIDTH+2 cycles between accepts.
- Assert `rst` asynchronously at mid-SHIFT (after E3 of 8'hB0) → all outputs return to reset values without waiting for an edge; no `done`; the next word 8'hB0 gives `match_count` = 1.
